// File: rtl/icache_axi_refill.sv
// AXI4 read-burst line filler for the icache: one INCR burst per line request,
// beats assembled into a line buffer, then a single-cycle grant.
module icache_axi_refill #(
  parameter int unsigned LINE_WORDS = 16,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         icache_rd_req,
  input  logic [31:0]                  icache_addr,
  output logic                         icache_gnt,
  output logic [LINE_WORDS-1:0][31:0]  icache_data,
  output logic [3:0]                   arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic                         bus_err
);

  localparam int unsigned CW = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_GNT
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [31:0]                   r_araddr;
  logic [CW-1:0]                 r_beat_cnt;
  logic                          r_err;
  logic [LINE_WORDS-1:0][31:0]   r_line;

  logic                          w_accept;
  logic                          w_beat;
  logic                          w_cnt_last;
  logic                          w_burst_end;

  assign w_accept    = (r_state == S_IDLE) && icache_rd_req;
  assign w_beat      = (r_state == S_R) && rvalid;
  assign w_cnt_last  = (r_beat_cnt == CW'(LINE_WORDS - 1));
  // The burst closes on whichever comes first: rlast or the final buffer slot.
  assign w_burst_end = w_beat && (rlast || w_cnt_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (icache_rd_req)       w_next = S_AR;
      S_AR:   if (arready)             w_next = S_R;
      S_R:    if (w_burst_end)         w_next = S_GNT;
      S_GNT:                           w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_araddr   <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_line     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_araddr   <= {icache_addr[31:6], 6'b0};
        r_beat_cnt <= '0;
        r_err      <= 1'b0;
      end
      if (w_beat) begin
        r_line[r_beat_cnt] <= rdata;
        r_beat_cnt         <= r_beat_cnt + CW'(1);
        if ((rresp != 2'b00) || (rlast != w_cnt_last)) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign arid        = AXI_ID;
  assign araddr      = r_araddr;
  assign arlen       = 8'(LINE_WORDS - 1);
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign arvalid     = (r_state == S_AR);
  assign rready      = (r_state == S_R);
  assign icache_gnt  = (r_state == S_GNT);
  assign bus_err     = (r_state == S_GNT) && r_err;
  assign icache_data = r_line;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: table of line fills checked through a scoreboard,
// plus hand-written reset sequences.
module tb_icache_axi_refill;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 icache_rd_req;
  logic [31:0]          icache_addr;
  logic                 icache_gnt;
  logic [15:0][31:0]    icache_data;
  logic [3:0]           arid;
  logic [31:0]          araddr;
  logic [7:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;
  logic                 bus_err;

  icache_axi_refill #(.LINE_WORDS(16), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_rd_req(icache_rd_req), .icache_addr(icache_addr),
    .icache_gnt(icache_gnt), .icache_data(icache_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          ar_delay;
    bit          toggle;
    int          rlast_beat;
    int          err_beat;
    bit          drop;
    bit          exp_err;
    int          exp_gnt;
  } tc_t;

  typedef struct packed {
    logic [15:0][31:0] line;
    logic              err;
  } exp_t;

  tc_t          tbl[7];
  exp_t         sbq[$];
  logic [31:0]  model[16];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_burst(input tc_t tc);
    int          cyc, ar_wait, beat;
    bit          rv_ph, done;
    exp_t        e;
    logic [31:0] exp_addr;
    exp_addr = {tc.addr[31:6], 6'b0};
    cyc = 0; ar_wait = 0; beat = 0; rv_ph = 1'b1; done = 1'b0;
    e = '0;
    @(negedge clk);
    icache_rd_req = 1'b1; icache_addr = tc.addr; arready = 1'b0; rvalid = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
      if (icache_gnt) begin
        icache_rd_req = 1'b0;
        check("gnt_cycle", cyc, tc.exp_gnt);
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard: gnt with no expected line, got 1 expected 0");
        end else begin
          e = sbq.pop_front();
          check("bus_err", bus_err, e.err);
          for (int k = 0; k < 16; k++) check($sformatf("data[%0d]", k), icache_data[k], e.line[k]);
        end
        done = 1'b1;
      end else if (arvalid) begin
        if (ar_wait == 0) begin
          check("arvalid_latency", cyc, 1);
          check("arid", arid, 4'd0);
          check("arlen", arlen, 8'd15);
          check("arsize", arsize, 3'b010);
          check("arburst", arburst, 2'b01);
        end
        check("araddr", araddr, exp_addr);
        arready = (ar_wait >= tc.ar_delay);
        ar_wait++;
      end else if (rready) begin
        icache_addr = ~tc.addr;
        if (tc.drop) icache_rd_req = 1'b0;
        if (!tc.toggle || rv_ph) begin
          rvalid = 1'b1;
          rdata  = tc.base + 32'(beat);
          rlast  = (beat == tc.rlast_beat);
          rresp  = (beat == tc.err_beat) ? 2'b10 : 2'b00;
          model[beat] = rdata;
          if (beat == tc.rlast_beat || beat == 15) begin
            for (int k = 0; k < 16; k++) e.line[k] = model[k];
            e.err = tc.exp_err;
            sbq.push_back(e);
          end
          beat++;
        end
        rv_ph = !rv_ph;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL gnt_timeout: no gnt after %0d cycles, expected gnt at %0d", cyc, tc.exp_gnt);
      icache_rd_req = 1'b0;
    end else begin
      @(negedge clk);
      check("gnt_one_cycle", icache_gnt, 1'b0);
      for (int k = 0; k < 16; k++) check($sformatf("data_hold[%0d]", k), icache_data[k], e.line[k]);
    end
  endtask

  initial begin
    bit gnt_seen;
    //              addr           base          dly tog rlast err drop eerr gnt
    tbl[0] = '{32'h1FC0_0044, 32'h0000_00A0, 0, 1'b0, 15, 99, 1'b0, 1'b0, 18};
    tbl[1] = '{32'h0000_1234, 32'h0000_1000, 5, 1'b1, 15, 99, 1'b0, 1'b0, 38};
    tbl[2] = '{32'h8000_00C0, 32'h0000_2000, 0, 1'b0,  7, 99, 1'b0, 1'b1, 10};
    tbl[3] = '{32'h4000_0000, 32'h0000_3000, 2, 1'b0, 15,  3, 1'b0, 1'b1, 20};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_4000, 0, 1'b0, 16, 99, 1'b0, 1'b1, 18};
    tbl[5] = '{32'h1234_5678, 32'h0000_5000, 1, 1'b0, 15, 99, 1'b1, 1'b0, 19};
    tbl[6] = '{32'h0000_0040, 32'h0000_6000, 0, 1'b1, 15,  0, 1'b0, 1'b1, 33};
    for (int k = 0; k < 16; k++) model[k] = '0;

    rst_n = 1'b0; icache_rd_req = 1'b0; icache_addr = '0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_gnt", icache_gnt, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_burst(tbl[i]);

    // Reset in the middle of a data phase: outputs clear at once, no grant follows.
    @(negedge clk);
    icache_rd_req = 1'b1; icache_addr = 32'h0BAD_0000; arready = 1'b1;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b0; rresp = 2'b00;
    repeat (7) @(negedge clk);
    check("pre_reset_in_R", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_arvalid", arvalid, 1'b0);
    check("midrst_rready", rready, 1'b0);
    check("midrst_gnt", icache_gnt, 1'b0);
    for (int k = 0; k < 16; k++) check($sformatf("midrst_data[%0d]", k), icache_data[k], 32'h0);
    icache_rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    gnt_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (icache_gnt || arvalid) gnt_seen = 1'b1;
    end
    check("no_activity_after_reset", gnt_seen, 1'b0);
    check("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
